// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and helpers for the sequential RV32M divider
package div_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_DIV  = 2'b00;
    localparam op_t OP_DIVU = 2'b01;
    localparam op_t OP_REM  = 2'b10;
    localparam op_t OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_ADJ  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // DIV and REM treat operands as two's-complement values
    function automatic logic op_is_signed(input op_t op);
        logic s;
        case (op)
            OP_DIV:  s = 1'b1;
            OP_DIVU: s = 1'b0;
            OP_REM:  s = 1'b1;
            OP_REMU: s = 1'b0;
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic op_is_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_32bits_seq_if.sv
// rtl/div_32bits_seq_if.sv - start/busy/done request bundle of the divider
interface div_32bits_seq_if;
    import div_pkg::*;

    logic        start;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/adder_32bits.sv
// rtl/adder_32bits.sv - 32-bit ripple adder with carry in and carry out
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co
);

    // Plain binary addition; the divider drives b=~x, ci=1 to subtract/negate
    always_comb begin
        {co, sum} = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    end

endmodule

// File: rtl/div_32bits_seq.sv
// rtl/div_32bits_seq.sv - iterative restoring divider for DIV/DIVU/REM/REMU
module div_32bits_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    div_32bits_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               is_rem_q, is_rem_d;
    logic               done_q, done_d;

    logic               accept;
    logic               div_zero;
    logic               overflow;
    logic               sgn;
    logic [WIDTH:0]     shifted;
    logic               no_borrow;
    logic [WIDTH-1:0]   adj_sel;
    logic               adj_neg;

    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;
    logic               add_co;

    // Single adder: trial subtraction in CALC, two's-complement negate in ADJ
    adder_32bits u_adder (
        .a   (add_a),
        .b   (add_b),
        .ci  (1'b1),
        .sum (add_sum),
        .co  (add_co)
    );

    // Request decode: acceptance window and the two early-exit cases
    always_comb begin
        accept   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sgn      = op_is_signed(bus.op);
        div_zero = (bus.b == '0);
        overflow = sgn && (bus.a == INT_MIN) && (bus.b == ALL_ONES);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = (div_zero || overflow) ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_d = ST_ADJ;
                end
            end
            ST_ADJ:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: busy decoded from state, done/result straight from flops
    always_comb begin
        bus.busy   = (state_q == ST_CALC) || (state_q == ST_ADJ);
        bus.done   = done_q;
        bus.result = result_q;
    end

    // Datapath: shift-subtract step, adder input mux and final sign fix
    always_comb begin
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;
        done_d   = (state_d == ST_DONE);

        shifted   = {rem_q, dvd_q[WIDTH-1]};
        adj_sel   = is_rem_q ? rem_q : dvd_q;
        adj_neg   = is_rem_q ? rneg_q : qneg_q;

        if (state_q == ST_ADJ) begin
            add_a = ~adj_sel;
            add_b = '0;
        end else begin
            add_a = shifted[WIDTH-1:0];
            add_b = ~dvs_q;
        end
        no_borrow = shifted[WIDTH] | add_co;

        if (accept) begin
            is_rem_d = op_is_rem(bus.op);
            qneg_d   = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d   = sgn && bus.a[WIDTH-1];
            dvd_d    = (sgn && bus.a[WIDTH-1]) ? (~bus.a + 32'd1) : bus.a;
            dvs_d    = (sgn && bus.b[WIDTH-1]) ? (~bus.b + 32'd1) : bus.b;
            rem_d    = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            if (div_zero) begin
                result_d = op_is_rem(bus.op) ? bus.a : ALL_ONES;
            end else if (overflow) begin
                result_d = op_is_rem(bus.op) ? '0 : INT_MIN;
            end
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q - CNT_W'(1);
            rem_d = no_borrow ? add_sum : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        end else if (state_q == ST_ADJ) begin
            result_d = adj_neg ? add_sum : adj_sel;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
            done_q   <= done_d;
        end
    end

endmodule
